// File: rtl/mac_acc_seq_pkg.sv
// Shared definitions for the MAC accumulate sequencer: mode/state encodings,
// default widths and the descriptor legality rule.
package mac_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_BF16 = 2'b00,
    MODE_FP8  = 2'b01,
    MODE_RSVD = 2'b10,
    MODE_INT4 = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A descriptor is usable only with a defined mode and at least one beat.
  function automatic logic cfg_legal(input logic [1:0] mode, input logic len_is_zero);
    return (mode != MODE_RSVD) && !len_is_zero;
  endfunction

endpackage

// File: rtl/mac_acc_seq_if.sv
// Descriptor, operand-beat and result handshakes of the MAC sequencer.
// The slave side is the sequencer; the master side is the job producer/consumer.
interface mac_acc_seq_if import mac_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_clear;

  logic             op_valid;
  logic             op_ready;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W:0]   res_data;

  modport master (
    output cfg_valid, cfg_mode, cfg_len, cfg_clear, op_valid, res_ready,
    input  cfg_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_len, cfg_clear, op_valid, res_ready,
    output cfg_ready, op_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_acc_seq.sv
// Job sequencer for an external align/add datapath: accepts a descriptor,
// streams operand beats, keeps the accumulator and sticky overflow, returns a result.
module mac_acc_seq import mac_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mac_acc_seq_if.slave bus,
  input  logic        abort,
  output logic [1:0]  dp_mode,
  output logic        dp_en,
  input  logic [15:0] dp_sum_bf,
  input  logic        dp_cout_bf,
  input  logic [7:0]  dp_s_fp,
  input  logic        dp_c_fp,
  output logic [15:0] acc_bf,
  output logic [7:0]  acc_fp,
  output logic        err
);

  state_t           state_reg;
  mode_t            mode_reg;
  logic [LEN_W-1:0] beat_cnt_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             cfg_ready_reg;
  logic             op_ready_reg;
  logic             res_valid_reg;
  logic             err_reg;

  logic [ACC_W-1:0] beat_sum;
  logic             beat_carry;
  logic             beat_accept;
  logic             last_beat;
  logic             cfg_accept;

  assign beat_accept = bus.op_valid && op_ready_reg;
  assign last_beat   = (beat_cnt_reg == LEN_W'(1));
  assign cfg_accept  = bus.cfg_valid && cfg_ready_reg;

  // FP8/INT4 results occupy the low byte; the upper accumulator bits are zeroed.
  always_comb begin
    beat_sum   = '0;
    beat_carry = 1'b0;
    if (mode_reg == MODE_BF16) begin
      beat_sum   = ACC_W'(dp_sum_bf);
      beat_carry = dp_cout_bf;
    end else begin
      beat_sum   = ACC_W'(dp_s_fp);
      beat_carry = dp_c_fp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_BF16;
      beat_cnt_reg  <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cfg_ready_reg <= 1'b1;
      op_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // abort here is a no-op and also suppresses any offered descriptor
          if (!abort && cfg_accept) begin
            if (!cfg_legal(bus.cfg_mode, bus.cfg_len == '0)) begin
              err_reg <= 1'b1;
            end else begin
              state_reg     <= RUN;
              mode_reg      <= mode_t'(bus.cfg_mode);
              beat_cnt_reg  <= bus.cfg_len;
              cfg_ready_reg <= 1'b0;
              op_ready_reg  <= 1'b1;
              if (bus.cfg_clear) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
              end
            end
          end
        end

        RUN: begin
          if (abort) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_BF16;
            beat_cnt_reg  <= '0;
            ovf_reg       <= 1'b0;
            cfg_ready_reg <= 1'b1;
            op_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
          end else if (beat_accept) begin
            acc_reg      <= beat_sum;
            ovf_reg      <= ovf_reg | beat_carry;
            beat_cnt_reg <= beat_cnt_reg - LEN_W'(1);
            if (last_beat) begin
              state_reg     <= DONE;
              op_ready_reg  <= 1'b0;
              res_valid_reg <= 1'b1;
            end
          end
        end

        DONE: begin
          // The accumulator is kept on exit so a cfg_clear=0 job can chain from it.
          if (abort) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_BF16;
            beat_cnt_reg  <= '0;
            ovf_reg       <= 1'b0;
            cfg_ready_reg <= 1'b1;
            op_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
          end else if (bus.res_ready) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_BF16;
            cfg_ready_reg <= 1'b1;
            res_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          mode_reg      <= MODE_BF16;
          beat_cnt_reg  <= '0;
          cfg_ready_reg <= 1'b1;
          op_ready_reg  <= 1'b0;
          res_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.op_ready  = op_ready_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = {ovf_reg, acc_reg};

  assign dp_mode = mode_reg;
  assign dp_en   = beat_accept;
  assign acc_bf  = 16'(acc_reg);
  assign acc_fp  = 8'(acc_reg);
  assign err     = err_reg;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Self-checking bench for mac_acc_seq: directed scenarios plus randomized jobs,
// with a scoreboard queue fed by the stimulus and drained by a result monitor.
module tb_mac_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [1:0]  dp_mode;
  logic        dp_en;
  logic [15:0] dp_sum_bf;
  logic        dp_cout_bf;
  logic [7:0]  dp_s_fp;
  logic        dp_c_fp;
  logic [15:0] acc_bf;
  logic [7:0]  acc_fp;
  logic        err;

  mac_acc_seq_if #(.LEN_W(8), .ACC_W(16)) bus ();

  mac_acc_seq #(.LEN_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort(abort),
    .dp_mode(dp_mode), .dp_en(dp_en),
    .dp_sum_bf(dp_sum_bf), .dp_cout_bf(dp_cout_bf),
    .dp_s_fp(dp_s_fp), .dp_c_fp(dp_c_fp),
    .acc_bf(acc_bf), .acc_fp(acc_fp), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;

  logic [16:0] exp_q[$];
  logic [16:0] direct_q[$];

  // Datapath stand-in: either an adder of the fed-back accumulator and an operand,
  // or a directly imposed {carry, sum} for directed cases.
  logic        direct_en;
  logic [16:0] direct_val;
  logic [15:0] op_val;
  logic [16:0] stub_bf;
  logic [8:0]  stub_fp;
  logic        hold_ready;
  int          stall_mode;

  // Reference state: accumulator value, sticky overflow, active mode.
  logic [15:0] model_acc;
  logic        model_ovf;
  logic [1:0]  cur_mode;

  assign stub_bf = {1'b0, acc_bf} + {1'b0, op_val};
  assign stub_fp = {1'b0, acc_fp} + {1'b0, op_val[7:0]};

  always_comb begin
    dp_sum_bf  = stub_bf[15:0];
    dp_cout_bf = stub_bf[16];
    dp_s_fp    = stub_fp[7:0];
    dp_c_fp    = stub_fp[8];
    if (direct_en) begin
      dp_sum_bf  = direct_val[15:0];
      dp_cout_bf = direct_val[16];
      dp_s_fp    = direct_val[7:0];
      dp_c_fp    = direct_val[16];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  always @(posedge clk) if (dp_en) en_cnt++;

  // Result monitor: every completed result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {15'd0, bus.res_data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("res_data", {15'd0, bus.res_data}, {15'd0, e});
        $display("[TB] result 0x%05h expected 0x%05h", bus.res_data, e);
      end
    end
  end

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_checks(input string tag);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 1);
    check({tag, "_op_ready"},  bus.op_ready,  0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_dp_en"},     dp_en,         0);
    check({tag, "_err"},       err,           0);
    check({tag, "_dp_mode"},   dp_mode,       0);
    check({tag, "_acc_bf"},    acc_bf,        0);
    check({tag, "_acc_fp"},    acc_fp,        0);
  endtask

  task automatic send_cfg(input logic [1:0] m, input int len, input bit clr);
    int n = 0;
    while (!bus.cfg_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cfg_ready) timeout_fail("cfg_ready_wait");
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = m;
    bus.cfg_len   = 8'(len);
    bus.cfg_clear = clr;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    if (m != 2'b10 && len != 0) begin
      cur_mode = m;
      if (clr) begin
        model_acc = '0;
        model_ovf = 1'b0;
      end
    end
    $display("[TB] cfg mode=%0d len=%0d clear=%0d", m, len, clr);
  endtask

  task automatic model_beat(input bit direct, input logic [16:0] dv, input logic [15:0] ov);
    logic [16:0] s;
    logic [8:0]  t;
    if (direct) begin
      s = dv;
      if (cur_mode != 2'b00) s[15:8] = 8'h00;
    end else if (cur_mode == 2'b00) begin
      s = {1'b0, model_acc} + {1'b0, ov};
    end else begin
      t = {1'b0, model_acc[7:0]} + {1'b0, ov[7:0]};
      s = {t[8], 8'h00, t[7:0]};
    end
    model_acc = s[15:0];
    model_ovf = model_ovf | s[16];
  endtask

  // Streams len beats; abort_at (1-based, 0 = never) asserts abort with that beat.
  task automatic beats(input int len, input int abort_at, input bit use_force,
                       input logic [16:0] force_exp, output bit aborted);
    int  sent = 0;
    int  cyc = 0;
    bit  dir;
    aborted = 1'b0;
    while (sent < len && cyc < 500 && !aborted) begin
      case (stall_mode)
        0:       bus.op_valid = ($urandom_range(0, 3) != 0);
        1:       bus.op_valid = (cyc % 2 == 0);
        default: bus.op_valid = 1'b1;
      endcase
      dir = (direct_q.size() > sent);
      direct_en  = dir;
      direct_val = dir ? direct_q[sent] : 17'd0;
      op_val     = 16'($urandom);
      abort      = (abort_at == sent + 1) && bus.op_valid;
      @(negedge clk);
      if (cyc == 0) check("dp_mode_run", dp_mode, cur_mode);
      if (abort) aborted = 1'b1;
      else if (dp_en) begin
        model_beat(dir, direct_val, op_val);
        sent++;
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      cyc++;
    end
    bus.op_valid = 1'b0;
    direct_en    = 1'b0;
    if (aborted) begin
      model_ovf = 1'b0;
    end else if (sent < len) begin
      timeout_fail("beat_stream");
    end else begin
      exp_q.push_back(use_force ? force_exp : {model_ovf, model_acc});
      check("res_latency", bus.res_valid, 1);
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("result_wait");
  endtask

  bit ab;
  int n0;

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode = 2'b00;
    bus.cfg_len = 8'd0;
    bus.cfg_clear = 1'b0;
    bus.op_valid = 1'b0;
    direct_en = 1'b0;
    direct_val = '0;
    op_val = '0;
    hold_ready = 1'b0;
    stall_mode = 2;
    model_acc = '0;
    model_ovf = 1'b0;
    cur_mode = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("por");
    @(posedge clk);
    #1;

    // BF16, three beats, datapath returns 0x0010/0x0030/0x0070
    direct_q = '{17'h00010, 17'h00030, 17'h00070};
    send_cfg(2'b00, 3, 1'b1);
    beats(3, 0, 1'b1, 17'h00070, ab);
    wait_result();

    // FP8, carry on first beat, sums 0x05 then 0x09
    direct_q = '{17'h10005, 17'h00009};
    send_cfg(2'b01, 2, 1'b1);
    beats(2, 0, 1'b1, 17'h10009, ab);
    wait_result();
    direct_q.delete();

    // Illegal descriptors: reserved mode, zero length
    send_cfg(2'b10, 3, 1'b1);
    check("rsvd_err", err, 1);
    check("rsvd_cfg_ready", bus.cfg_ready, 1);
    @(posedge clk);
    #1;
    check("rsvd_err_pulse", err, 0);
    check("rsvd_op_ready", bus.op_ready, 0);
    send_cfg(2'b00, 0, 1'b1);
    check("len0_err", err, 1);
    @(posedge clk);
    #1;
    check("len0_err_pulse", err, 0);
    check("len0_cfg_ready", bus.cfg_ready, 1);

    // abort in IDLE swallows a simultaneous descriptor
    abort = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_mode = 2'b00;
    bus.cfg_len = 8'd3;
    bus.cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    bus.cfg_valid = 1'b0;
    check("idle_abort_cfg_ready", bus.cfg_ready, 1);
    check("idle_abort_op_ready", bus.op_ready, 0);
    check("idle_abort_err", err, 0);

    // INT4, op_valid every other cycle, result held while res_ready stays low
    hold_ready = 1'b1;
    stall_mode = 1;
    send_cfg(2'b11, 4, 1'b1);
    n0 = en_cnt;
    beats(4, 0, 1'b0, 17'd0, ab);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_res_data", {15'd0, bus.res_data}, {15'd0, exp_q[0]});
    end
    hold_ready = 1'b0;
    wait_result();
    repeat (3) @(posedge clk);
    #1;
    check("int4_dp_en_pulses", en_cnt - n0, 4);

    // abort together with the 2nd beat of a 3-beat job, then chain from it
    stall_mode = 2;
    direct_q = '{17'h10111, 17'h00222, 17'h00333};
    send_cfg(2'b00, 3, 1'b1);
    beats(3, 2, 1'b0, 17'd0, ab);
    direct_q.delete();
    check("abort_taken", ab, 1);
    check("abort_cfg_ready", bus.cfg_ready, 1);
    check("abort_op_ready", bus.op_ready, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_acc_bf", acc_bf, 16'h0111);
    send_cfg(2'b00, 2, 1'b0);
    beats(2, 0, 1'b0, 17'd0, ab);
    wait_result();

    // Randomized jobs over all legal modes with random stalls and back-pressure
    stall_mode = 0;
    for (int j = 0; j < 30; j++) begin
      logic [1:0] m;
      int         len;
      case ($urandom_range(0, 2))
        0:       m = 2'b00;
        1:       m = 2'b01;
        default: m = 2'b11;
      endcase
      len = $urandom_range(1, 6);
      send_cfg(m, len, 1'($urandom_range(0, 1)));
      beats(len, 0, 1'b0, 17'd0, ab);
      wait_result();
    end

    // Reset asserted mid-job between clock edges
    stall_mode = 2;
    send_cfg(2'b01, 5, 1'b1);
    bus.op_valid = 1'b1;
    op_val = 16'h00A5;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.op_valid = 1'b0;
    model_acc = '0;
    model_ovf = 1'b0;
    cur_mode = 2'b00;

    stall_mode = 0;
    send_cfg(2'b00, 3, 1'b0);
    beats(3, 0, 1'b0, 17'd0, ab);
    wait_result();

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_acc_seq.md
MAC_ACC_SEQ -- requirements
Module: mac_acc_seq

Interface
REQ-001 SHALL provide parameter LEN_W, default 8, width of the beat-count field.
REQ-002 SHALL provide parameter ACC_W, default 16, width of the accumulator (BF16 mantissa sum).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cfg_valid  in  1  job descriptor offered.
REQ-006 cfg_ready  out  1  descriptor accepted when cfg_valid&&cfg_ready.
REQ-007 cfg_mode  in  2  00 BF16, 01 FP8, 11 INT4, 10 reserved.
REQ-008 cfg_len  in  LEN_W  number of operand beats in the job.
REQ-009 cfg_clear  in  1  1 zeroes the accumulator at job start; 0 chains the previous result.
REQ-010 op_valid / op_ready  in / out  1 / 1  operand-beat handshake to the align/add datapath.
REQ-011 abort  in  1  synchronous job cancel.
REQ-012 dp_mode  out  2  mode driven to the datapath, held for the whole job.
REQ-013 dp_en  out  1  high in every cycle in which a beat is accepted.
REQ-014 dp_sum_bf, dp_cout_bf  in  16, 1  BF16 datapath sum and carry.
REQ-015 dp_s_fp, dp_c_fp  in  8, 1  FP8/INT4 datapath sum and carry.
REQ-016 acc_bf, acc_fp  out  16, 8  accumulator fed back as the datapath addend.
REQ-017 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-018 res_data  out  ACC_W+1  {ovf, accumulator}; FP8/INT4 results are zero-extended in bits [15:8].
REQ-019 err  out  1  one-cycle pulse on an illegal descriptor.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-021 cfg_ready SHALL be high only in IDLE.
REQ-022 In IDLE, an accepted descriptor with mode 10 or cfg_len==0 SHALL pulse err for one cycle and keep the FSM in IDLE.
REQ-023 In IDLE, a legal accepted descriptor SHALL latch mode, load beat_cnt=cfg_len, clear the accumulator and ovf if cfg_clear=1, and enter RUN on the next cycle.
REQ-024 op_ready SHALL be high only in RUN; dp_en SHALL equal op_valid&&op_ready.
REQ-025 Each accepted beat SHALL, on that clock edge, load the accumulator from the datapath, decrement beat_cnt, and OR the datapath carry into ovf: BF16 takes acc_bf<=dp_sum_bf and dp_cout_bf; FP8/INT4 take acc_fp<=dp_s_fp and dp_c_fp.
REQ-026 Throughput SHALL be one beat per cycle; op_valid low stalls RUN with no state change.
REQ-027 Acceptance of the beat with beat_cnt==1 SHALL move the FSM to DONE; res_valid SHALL be high the following cycle (latency 1 after the last beat).
REQ-028 In DONE, res_data SHALL be held stable until res_ready; on res_valid&&res_ready the FSM SHALL return to IDLE and the accumulator SHALL be retained for chaining.
REQ-029 abort in RUN or DONE SHALL force IDLE on the next edge, drop res_valid, and clear ovf; abort SHALL win over a simultaneous beat or result handshake.
REQ-030 abort in IDLE SHALL have no effect; a simultaneous cfg_valid in that cycle SHALL be ignored.
REQ-031 dp_mode SHALL drive 00 in IDLE and the latched mode in RUN and DONE.
REQ-032 The accumulator SHALL wrap modulo its width; overflow SHALL be reported only through the sticky ovf bit.

Reset
REQ-033 rst SHALL force state IDLE, beat_cnt 0, acc_bf 0, acc_fp 0, ovf 0, dp_mode 00, and cfg_ready 1 (IDLE) after release, with res_valid, op_ready, dp_en and err all 0.
REQ-034 rst asserted mid-job SHALL discard the job with no result produced.

Structure
REQ-035 A shared package mac_pkg SHALL hold the mode enum (MODE_BF16, MODE_FP8, MODE_RSVD, MODE_INT4), the state enum, and the LEN_W/ACC_W defaults.
REQ-036 The block SHALL be a single module with no sub-modules; the datapath SHALL be instantiated outside it.

Verification
REQ-037 BF16, cfg_len=3, cfg_clear=1, dp_sum_bf returns 0x0010, 0x0030, 0x0070 with no carry -> res_data=0x00070 one cycle after the third beat.
REQ-038 FP8, cfg_len=2, dp_c_fp=1 on the first beat, dp_s_fp=0x05 then 0x09 -> res_data={1,0x0009}, with ovf sticky.
REQ-039 cfg_mode=10 or cfg_len=0 -> err high for exactly 1 cycle, FSM stays in IDLE, cfg_ready stays 1.
REQ-040 INT4, cfg_len=4, op_valid toggled every other cycle -> exactly 4 dp_en pulses, and res_valid is held while res_ready=0 for 5 cycles.
REQ-041 abort asserted together with the 2nd beat of a 3-beat job -> no res_valid, IDLE next cycle, and the next job with cfg_clear=0 starts from the pre-abort accumulator.
REQ-042 rst asserted in RUN -> all outputs reach their reset values asynchronously, before the next clk edge.
